// File: rtl/sram_pkg.sv
// Shared SRAM geometry constants and the read prefetcher state encoding.
package sram_pkg;
    localparam int SRAM_ADDR_WIDTH   = 20;
    localparam int SRAM_DATA_WIDTH   = 18;
    localparam int SRAM_READ_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } pf_state_e;
endpackage

// File: rtl/sram_read_prefetcher_chk.sv
// Protocol checker for the prefetcher output buffer.
module sram_read_prefetcher_chk (
    input logic clk,
    input logic reset,
    input logic push,
    input logic full
);
    // The credit scheme must make a push into a full buffer impossible.
    no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && full));
endmodule

// File: rtl/sram_read_prefetcher_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and synchronous flush.
module sync_fifo #(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic                   pop,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  do_push_s, do_pop_s;

    // Next-state for storage, pointers and occupancy; flush beats push/pop.
    always_comb begin
        do_pop_s  = pop && (count_q != '0);
        do_push_s = push && ((count_q != DEPTH_C) || do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head word is forced to zero while empty so stale entries never leak out.
    always_comb begin
        if (count_q == '0) begin
            rdata = '0;
        end else begin
            rdata = mem_q[rd_ptr_q];
        end
    end

    assign count = count_q;
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
endmodule

// File: rtl/sram_read_prefetcher.sv
// Turns a (base, count) job into credit-limited pipelined SRAM reads and
// streams the returned words to a valid/ready consumer.
module sram_read_prefetcher
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH   = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH   = SRAM_DATA_WIDTH,
    parameter int READ_LATENCY = SRAM_READ_LATENCY,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_req,
    output logic                  sram_write_enable,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]           DEPTH_C  = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    pf_state_e               state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_ptr_q, addr_ptr_d;
    logic [ADDR_WIDTH-1:0]   remaining_q, remaining_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic                    done_q, done_d;
    logic [CW-1:0]           fifo_count_s, inflight_s;
    logic [CW:0]             credit_used_s;
    logic                    fifo_full_s, fifo_empty_s;
    logic                    issue_s, push_s, pop_s, flush_s, finishing_s;

    // Reads in flight are the set bits of the latency shift register.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_s = inflight_s + CW'(pipe_q[i]);
        end
    end

    // Credit check and the "buffer empties at this edge" job-completion test.
    always_comb begin
        credit_used_s = {1'b0, fifo_count_s} + {1'b0, inflight_s};
        issue_s       = (state_q == FETCH) && (remaining_q != '0) && (credit_used_s < DEPTH_C);
        push_s        = pipe_q[READ_LATENCY-1];
        pop_s         = !fifo_empty_s && out_ready;
        finishing_s   = (remaining_q == '0) && (inflight_s == '0)
                        && ((fifo_count_s == '0) || ((fifo_count_s == CNT_ONE) && pop_s));
    end

    // Job FSM: done is raised for the cycle right after the final pop.
    always_comb begin
        state_d     = state_q;
        addr_ptr_d  = addr_ptr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        flush_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (word_count != '0) begin
                        state_d     = FETCH;
                        addr_ptr_d  = base_addr;
                        remaining_d = word_count;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d = IDLE;
                    flush_s = 1'b1;
                end else if (issue_s) begin
                    addr_ptr_d  = addr_ptr_q + ADDR_ONE;
                    remaining_d = remaining_q - ADDR_ONE;
                end else if (remaining_q == '0) begin
                    if (finishing_s) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                    flush_s = 1'b1;
                end else if (finishing_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                flush_s = 1'b1;
            end
        endcase
    end

    // Stage 0 takes this cycle's request; abort discards late returns.
    always_comb begin
        pipe_d = '0;
        if (flush_s) begin
            pipe_d = '0;
        end else begin
            pipe_d[0] = issue_s;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_ptr_q  <= '0;
            remaining_q <= '0;
            pipe_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_ptr_q  <= addr_ptr_d;
            remaining_q <= remaining_d;
            pipe_q      <= pipe_d;
            done_q      <= done_d;
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush_s),
        .push  (push_s),
        .wdata (sram_rdata),
        .pop   (pop_s),
        .rdata (out_data),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    sram_read_prefetcher_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .full  (fifo_full_s)
    );

    assign busy              = (state_q != IDLE);
    assign done              = done_q;
    assign sram_req          = issue_s;
    assign sram_addr         = addr_ptr_q;
    assign sram_write_enable = 1'b0;
    assign out_valid         = !fifo_empty_s;
endmodule

// File: tb/tb_sram_read_prefetcher.sv
// Randomized self-checking bench for sram_read_prefetcher with a job-level reference model.
module tb_sram_read_prefetcher;
    localparam int L = 2;
    localparam int D = 8;

    logic        clk, reset, start, abort, out_ready;
    logic [19:0] base_addr, word_count;
    logic        busy, done, sram_req, sram_write_enable, out_valid;
    logic [19:0] sram_addr;
    logic [17:0] sram_rdata, out_data;

    int n_chk = 0;
    int n_err = 0;
    int pops_total = 0;
    bit rand_ready = 0;

    sram_read_prefetcher dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .abort(abort), .busy(busy), .done(done),
        .sram_addr(sram_addr), .sram_req(sram_req), .sram_write_enable(sram_write_enable),
        .sram_rdata(sram_rdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // SRAM model: the word stored at an address is its low 18 address bits.
    logic [17:0] sram_pipe [L];
    always @(posedge clk) begin
        sram_pipe[0] <= sram_req ? sram_addr[17:0] : 18'h3FFFF;
        for (int i = 1; i < L; i++) sram_pipe[i] <= sram_pipe[i-1];
    end
    assign sram_rdata = sram_pipe[L-1];

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Job-level reference model: expected address/data queues and done/busy timing.
    logic [19:0] exp_addr[$];
    logic [17:0] exp_data[$];
    bit job_active = 0;
    bit done_pend  = 0;
    int left_cnt   = 0;
    int outstanding = 0;

    initial begin
        bit new_pend, active_now;
        logic [19:0] a;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_addr.delete(); exp_data.delete();
                job_active = 0; done_pend = 0; left_cnt = 0; outstanding = 0;
            end else begin
                chk_eq("done", done, done_pend);
                chk_eq("busy", busy, job_active);
                active_now = job_active;
                new_pend = 0;
                if (sram_req) begin
                    if (exp_addr.size() == 0) chk_eq("unexpected_req", 1, 0);
                    else chk_eq("sram_addr", sram_addr, exp_addr.pop_front());
                    outstanding++;
                    chk_eq("credit", (outstanding <= D), 1);
                end
                if (out_valid && out_ready) begin
                    pops_total++;
                    if (exp_data.size() == 0) chk_eq("unexpected_pop", 1, 0);
                    else chk_eq("out_data", out_data, exp_data.pop_front());
                    outstanding--;
                    left_cnt--;
                    if (left_cnt == 0 && active_now) begin
                        new_pend = 1;
                        job_active = 0;
                    end
                end
                if (abort && active_now) begin
                    exp_addr.delete(); exp_data.delete();
                    job_active = 0; new_pend = 0; left_cnt = 0; outstanding = 0;
                end else if (start && !abort && !active_now) begin
                    if (word_count == 20'd0) begin
                        new_pend = 1;
                    end else begin
                        job_active = 1;
                        left_cnt = int'(word_count);
                        for (int i = 0; i < int'(word_count); i++) begin
                            a = base_addr + 20'(i);
                            exp_addr.push_back(a);
                            exp_data.push_back(a[17:0]);
                        end
                    end
                end
                done_pend = new_pend;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic start_job(input logic [19:0] b, input logic [19:0] n);
        start = 1'b1; base_addr = b; word_count = n;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            cyc();
        end
        chk_eq("wait_done", seen, 1);
    endtask

    initial begin
        logic [9:0]  req_v, val_v, done_v, busy_v, e_req, e_val, e_done, e_busy;
        logic [17:0] data_v [10];
        logic [19:0] got_a [$];
        logic [19:0] wrap_exp [4];
        int n, p0, wc;
        bit seen;

        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        base_addr = 20'd0; word_count = 20'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_req", sram_req, 0);
        chk_eq("rst_addr", sram_addr, 0);
        chk_eq("rst_valid", out_valid, 0);
        chk_eq("rst_data", out_data, 0);
        chk_eq("rst_we", sram_write_enable, 0);
        reset = 1'b0;
        cyc();

        // Basic job: exact cycle timing with the consumer always ready.
        out_ready = 1'b1;
        start_job(20'h00010, 20'd4);
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            req_v[c] = sram_req; val_v[c] = out_valid; done_v[c] = done; busy_v[c] = busy;
            data_v[c] = out_data;
            cyc();
        end
        req_v[0] = 0; val_v[0] = 0; done_v[0] = 0; busy_v[0] = 0;
        for (int c = 0; c < 10; c++) begin
            e_req[c]  = (c >= 1 && c <= 4);
            e_val[c]  = (c >= 4 && c <= 7);
            e_done[c] = (c == 8);
            e_busy[c] = (c >= 1 && c <= 7);
        end
        chk_eq("basic_req", req_v, e_req);
        chk_eq("basic_valid", val_v, e_val);
        chk_eq("basic_done", done_v, e_done);
        chk_eq("basic_busy", busy_v, e_busy);
        for (int c = 4; c <= 7; c++) chk_eq("basic_data", data_v[c], 18'(16 + c - 4));

        // Backpressure: credits stop issue at FIFO_DEPTH outstanding reads.
        out_ready = 1'b0;
        p0 = pops_total;
        start_job(20'h00100, 20'd20);
        n = 0;
        for (int c = 1; c < 30; c++) begin
            @(negedge clk);
            if (sram_req) n++;
            if (c == 29) chk_eq("bp_head", out_data, 18'h00100);
            cyc();
        end
        chk_eq("bp_req_count", n, 8);
        out_ready = 1'b1;
        wait_done(200);
        chk_eq("bp_pops", pops_total - p0, 20);

        // Address wrap across the top of the address space.
        rand_ready = 1;
        wrap_exp[0] = 20'hFFFFE; wrap_exp[1] = 20'hFFFFF; wrap_exp[2] = 20'h00000; wrap_exp[3] = 20'h00001;
        start_job(20'hFFFFE, 20'd4);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (sram_req) got_a.push_back(sram_addr);
            if (done) seen = 1;
            cyc();
        end
        chk_eq("wrap_done", seen, 1);
        chk_eq("wrap_count", got_a.size(), 4);
        for (int i = 0; i < 4 && i < got_a.size(); i++) chk_eq("wrap_addr", got_a[i], wrap_exp[i]);

        // Zero-length job, then a start while busy that must be ignored.
        start_job(20'h12345, 20'd0);
        @(negedge clk);
        chk_eq("zero_done", done, 1);
        chk_eq("zero_req", sram_req, 0);
        cyc();
        @(negedge clk);
        chk_eq("zero_done_clr", done, 0);
        cyc();
        p0 = pops_total;
        start_job(20'h00200, 20'd6);
        cyc();
        start_job(20'h00300, 20'd5);
        wait_done(200);
        chk_eq("busy_start_pops", pops_total - p0, 6);

        // Abort with words buffered and in flight.
        rand_ready = 0;
        out_ready = 1'b0;
        start_job(20'h00400, 20'd16);
        repeat (4) cyc();
        abort = 1'b1;
        @(negedge clk);
        chk_eq("abort_pre_valid", out_valid, 1);
        cyc();
        abort = 1'b0;
        @(negedge clk);
        chk_eq("abort_busy", busy, 0);
        chk_eq("abort_valid", out_valid, 0);
        chk_eq("abort_req", sram_req, 0);
        chk_eq("abort_done", done, 0);
        cyc();
        out_ready = 1'b1;
        p0 = pops_total;
        start_job(20'h00500, 20'd5);
        wait_done(200);
        chk_eq("abort_new_pops", pops_total - p0, 5);

        // Asynchronous reset in the middle of a job.
        rand_ready = 1;
        start_job(20'h00600, 20'd10);
        repeat (5) cyc();
        #2;
        reset = 1'b1;
        #1;
        chk_eq("mid_rst_busy", busy, 0);
        chk_eq("mid_rst_done", done, 0);
        chk_eq("mid_rst_req", sram_req, 0);
        chk_eq("mid_rst_addr", sram_addr, 0);
        chk_eq("mid_rst_valid", out_valid, 0);
        chk_eq("mid_rst_data", out_data, 0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk_eq("post_rst_valid", out_valid, 0);
        cyc();
        p0 = pops_total;
        start_job(20'h00700, 20'd3);
        wait_done(200);
        chk_eq("post_rst_pops", pops_total - p0, 3);

        // Random jobs with random backpressure and occasional aborts.
        for (int j = 0; j < 25; j++) begin
            wc = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
            p0 = pops_total;
            start_job(20'($urandom), 20'(wc));
            if (wc == 0) begin
                cyc();
            end else if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(0, wc + 4)) cyc();
                abort = 1'b1;
                cyc();
                abort = 1'b0;
                @(negedge clk);
                chk_eq("rnd_abort_busy", busy, 0);
                cyc();
            end else begin
                wait_done(400);
                chk_eq("rnd_pops", pops_total - p0, wc);
            end
        end

        repeat (3) cyc();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
